fx_format_convert: RTL and testbench
====================================

# fx_format_convert

Parametrised fixed-point format converter with selectable quantisation and overflow handling, a configurable register pipeline with valid qualification, and overflow monitoring. It succeeds the fixed-format matchers (hard-wired LSB pad / MSB wrap followed by a fixed delay). It sits between datapath stages whose Q-formats differ, at every width-change point in the generated RTL.

## Interface
- IW, 16, input word width
- IF, 8, input fractional bits (0 ≤ IF ≤ IW)
- OW, 12, output word width
- OF, 10, output fractional bits (0 ≤ OF ≤ OW)
- SIGNED, 1, 1 = two's complement, 0 = unsigned (applies to input and output)
- QUAN_MODE, 0, 0 = truncate (floor), 1 = round half up, 2 = convergent (round half to even)
- OVF_MODE, 0, 0 = wrap (keep LSBs), 1 = saturate
- LATENCY, 1, number of register stages, ≥ 1
- CNT_W, 16, overflow counter width
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  reset, synchronous, active-high
- i_valid  in  1  input sample qualifier
- i_data  in  IW  input sample
- i_cnt_clr  in  1  synchronous clear of o_ovf_cnt
- o_valid  out  1  output qualifier, i_valid delayed by LATENCY
- o_data  out  OW  converted sample
- o_ovf  out  1  overflow or saturation occurred on this sample, aligned with o_data
- o_ovf_cnt  out  CNT_W  saturating count of output samples with o_ovf = 1

## Operation
- Alignment: if OF ≥ IF, append OF−IF zero LSBs. This path is exact, and QUAN_MODE has no effect.
- If OF < IF, drop D = IF−OF LSBs:
  - Truncate: floor.
  - Half up: add 1 at bit D−1, then floor.
  - Convergent: same as half up, except when the dropped bits equal exactly 100…0; then round to the even result.
- Rounding is computed one bit wider than the input, so a carry out of the MSB is never lost.
- Overflow check on the aligned/rounded value:
  - Signed: overflow when the bits above OW−1 are not all equal to bit OW−1.
  - Unsigned: overflow when any bit above OW−1 is nonzero.
- On overflow:
  - Wrap: output the OW LSBs.
  - Saturate: output max (signed 0111…1, unsigned 1…1) or signed min (1000…0), chosen by the sign of the pre-overflow value.
- o_ovf = 1 whenever overflow is detected, in both overflow modes.
- Pipeline: stage 1 registers the quantised result, the overflow flag and i_valid. Stages 2..LATENCY are a plain delay line.
- Data and flag registers of a stage load only when that stage's valid input is 1, and hold otherwise. The valid bits shift every cycle. No backpressure.
- Counter behaviour:
  - o_ovf_cnt increments when o_valid & o_ovf, and sticks at 2^CNT_W−1.
  - i_cnt_clr has priority: clear together with an overflowing sample in the same cycle gives 0.

## Timing
- Reset: all pipeline registers, o_valid, o_data, o_ovf and o_ovf_cnt go to 0 in the cycle after rst is sampled high.
- Reset mid-stream: in-flight samples are discarded, and o_valid = 0 until new samples traverse the pipeline.
- Latency is exactly LATENCY cycles: a sample with i_valid in cycle n appears with o_valid in cycle n+LATENCY.
- Throughput is one sample per cycle. Back-to-back and gapped valid patterns are preserved exactly.
- o_ovf_cnt reflects the output sample of cycle n in cycle n+1.

## Structure
- Shared package fx_pkg holds:
  - QUAN_TRUNC/QUAN_HALF_UP/QUAN_CONV and OVF_WRAP/OVF_SAT constants.
  - A function returning the signed/unsigned max/min for a width.
- Sub-module fx_delay_line(W, DEPTH) implements the valid-gated delay for stages 2..LATENCY. With DEPTH = 0 it is a pass-through.
- The quantise/overflow logic is combinational inside fx_format_convert and feeds stage 1.

## Test plan
- Default parameters, wrap, i_data 16'h0123 -> o_data 12'h48C, o_ovf 0. i_data 16'h0300 -> 12'hC00, o_ovf 1. With OVF_MODE 1, the same input -> 12'h7FF, o_ovf 1. i_data 16'hFC00 (−4.0) with saturate -> 12'h800, o_ovf 1.
- IW 8, IF 4, OW 6, OF 2, signed, per mode (truncate / half up / convergent):
  - i_data 8'h06 -> 6'h01 / 6'h02 / 6'h02
  - i_data 8'h0A -> 6'h02 / 6'h03 / 6'h02
  - i_data 8'hFA -> 6'h3E / 6'h3F / 6'h3E
- Rounding carry: same formats, half up, saturate, i_data 8'h7F -> 6'h1F, o_ovf 1. With wrap -> 6'h20, o_ovf 1.
- LATENCY 3, valid pattern 1,0,1,1 with data A, B, C in the valid cycles -> o_valid 1,0,1,1 starting at cycle 3, data A, A (held), B, C.
- CNT_W 4, twenty consecutive overflowing samples -> o_ovf_cnt stops at 15. Then i_cnt_clr together with an overflowing output -> 0 next cycle.
- rst asserted for 1 cycle with 3 samples in flight (LATENCY 3) -> no o_valid for the following 3 cycles. o_data, o_ovf and o_ovf_cnt read 0.

Source files
------------

// File: rtl/fx_pkg.sv
// fx_pkg: quantisation/overflow mode constants and saturation limit helper
package fx_pkg;

    localparam int QUAN_TRUNC   = 0;
    localparam int QUAN_HALF_UP = 1;
    localparam int QUAN_CONV    = 2;
    localparam int OVF_WRAP     = 0;
    localparam int OVF_SAT      = 1;

    // Bit pattern of the largest or smallest representable value of a w-bit word.
    function automatic logic [63:0] fx_limit(input int w, input bit sgn, input bit want_max);
        logic [63:0] one;
        one = 64'd1;
        if (sgn)
            return want_max ? (one << (w - 1)) - one : one << (w - 1);
        return want_max ? (one << w) - one : 64'd0;
    endfunction

endpackage

// File: rtl/fx_delay_line.sv
// fx_delay_line: valid-gated register delay line; each stage loads only when its valid input is set.
module fx_delay_line #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    if (DEPTH == 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign o_valid = i_valid;
        assign o_data  = i_data;
    end else begin : g_dly
        logic [DEPTH-1:0] v_q, v_d, v_in;
        logic [W-1:0]     d_q  [DEPTH];
        logic [W-1:0]     d_d  [DEPTH];
        logic [W-1:0]     d_in [DEPTH];
        assign v_in[0] = i_valid;
        assign d_in[0] = i_data;
        for (genvar j = 1; j < DEPTH; j++) begin : g_link
            assign v_in[j] = v_q[j-1];
            assign d_in[j] = d_q[j-1];
        end
        always_comb begin
            v_d = v_in;
            for (int k = 0; k < DEPTH; k++)
                d_d[k] = v_in[k] ? d_in[k] : d_q[k];
        end
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= '0;
                d_q <= '{default: '0};
            end else begin
                v_q <= v_d;
                d_q <= d_d;
            end
        end
        assign o_valid = v_q[DEPTH-1];
        assign o_data  = d_q[DEPTH-1];
    end

endmodule

// File: rtl/fx_format_convert.sv
// fx_format_convert: fixed-point Q-format converter with selectable rounding and overflow handling,
// a valid-qualified register pipeline and a saturating overflow counter.
module fx_format_convert
    import fx_pkg::*;
#(
    parameter int IW        = 16,
    parameter int IF        = 8,
    parameter int OW        = 12,
    parameter int OF        = 10,
    parameter int SIGNED    = 1,
    parameter int QUAN_MODE = 0,
    parameter int OVF_MODE  = 0,
    parameter int LATENCY   = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [IW-1:0]    i_data,
    input  logic             i_cnt_clr,
    output logic             o_valid,
    output logic [OW-1:0]    o_data,
    output logic             o_ovf,
    output logic [CNT_W-1:0] o_ovf_cnt
);

    localparam int SH  = (OF >= IF) ? OF - IF : 0;
    localparam int D   = (IF > OF) ? IF - OF : 0;
    localparam int EW0 = IW + SH + 1;
    // Working width keeps the rounding carry and always has at least one bit above the output MSB.
    localparam int EW  = (EW0 > OW + 1) ? EW0 : OW + 1;
    localparam logic [OW-1:0]    SAT_MAX = OW'(fx_limit(OW, SIGNED != 0, 1'b1));
    localparam logic [OW-1:0]    SAT_MIN = OW'(fx_limit(OW, SIGNED != 0, 1'b0));
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [EW-1:0] ext, val;
    logic          ovf;
    logic [OW-1:0] q_data;

    assign ext = (SIGNED != 0) ? {{(EW-IW){i_data[IW-1]}}, i_data} : {{(EW-IW){1'b0}}, i_data};

    if (D == 0) begin : g_align
        assign val = ext << SH;
    end else begin : g_round
        localparam logic [EW-1:0] HALF = EW'(1) << (D - 1);
        logic          tie;
        logic [EW-1:0] sum;
        // Convergent mode skips the half-LSB add on an exact tie whose floor is already even.
        always_comb begin
            tie = i_data[D-1:0] == HALF[D-1:0];
            sum = ext + ((QUAN_MODE == QUAN_TRUNC || (QUAN_MODE == QUAN_CONV && tie && !ext[D])) ? '0 : HALF);
            val = (SIGNED != 0) ? EW'($signed(sum) >>> D) : sum >> D;
        end
    end

    always_comb begin
        ovf = (SIGNED != 0) ? !((&val[EW-1:OW-1]) || !(|val[EW-1:OW-1])) : |val[EW-1:OW];
        q_data = (!ovf || OVF_MODE == OVF_WRAP) ? val[OW-1:0]
               : (SIGNED != 0 && val[EW-1]) ? SAT_MIN : SAT_MAX;
    end

    logic          v1_q, v1_d, f1_q, f1_d;
    logic [OW-1:0] d1_q, d1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        v1_d  = i_valid;
        d1_d  = i_valid ? q_data : d1_q;
        f1_d  = i_valid ? ovf : f1_q;
        cnt_d = i_cnt_clr ? '0 : (o_valid && o_ovf && cnt_q != CNT_MAX) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q  <= 1'b0;
            d1_q  <= '0;
            f1_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            v1_q  <= v1_d;
            d1_q  <= d1_d;
            f1_q  <= f1_d;
            cnt_q <= cnt_d;
        end
    end

    fx_delay_line #(.W(OW + 1), .DEPTH(LATENCY - 1)) u_dly (
        .clk     (clk),
        .rst     (rst),
        .i_valid (v1_q),
        .i_data  ({f1_q, d1_q}),
        .o_valid (o_valid),
        .o_data  ({o_ovf, o_data})
    );

    assign o_ovf_cnt = cnt_q;

endmodule

// File: tb/tb_fx_format_convert.sv
// tb_fx_format_convert: scoreboard bench driving several parameterisations of the converter in lockstep.
module tb_fx_format_convert;

    typedef struct packed {logic [11:0] d; logic o;} e16_t;
    typedef struct packed {
        logic [5:0] tr; logic tro; logic [5:0] hu; logic huo;
        logic [5:0] cv; logic cvo; logic [5:0] hs; logic hso;
    } e8_t;

    logic clk = 1'b0, rst = 1'b1, i_valid = 1'b0, i_cnt_clr = 1'b0;
    logic [15:0] i_d16 = '0;
    logic [7:0]  i_d8 = '0;
    always #5 clk = ~clk;

    logic        w_v, s_v, l_v, c_v, tr_v, hu_v, cv_v, hs_v;
    logic [11:0] w_d, s_d, l_d, c_d;
    logic        w_o, s_o, l_o, c_o, tr_o, hu_o, cv_o, hs_o;
    logic [5:0]  tr_d, hu_d, cv_d, hs_d;
    logic [15:0] w_n, s_n, l_n, tr_n, hu_n, cv_n, hs_n;
    logic [3:0]  c_n;

    fx_format_convert #(.OVF_MODE(0)) u_w (.clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_d16),
        .i_cnt_clr(i_cnt_clr), .o_valid(w_v), .o_data(w_d), .o_ovf(w_o), .o_ovf_cnt(w_n));
    fx_format_convert #(.OVF_MODE(1)) u_s (.clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_d16),
        .i_cnt_clr(i_cnt_clr), .o_valid(s_v), .o_data(s_d), .o_ovf(s_o), .o_ovf_cnt(s_n));
    fx_format_convert #(.LATENCY(3)) u_l (.clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_d16),
        .i_cnt_clr(i_cnt_clr), .o_valid(l_v), .o_data(l_d), .o_ovf(l_o), .o_ovf_cnt(l_n));
    fx_format_convert #(.CNT_W(4)) u_c (.clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_d16),
        .i_cnt_clr(i_cnt_clr), .o_valid(c_v), .o_data(c_d), .o_ovf(c_o), .o_ovf_cnt(c_n));
    fx_format_convert #(.IW(8), .IF(4), .OW(6), .OF(2), .QUAN_MODE(0)) u_tr (.clk(clk), .rst(rst),
        .i_valid(i_valid), .i_data(i_d8), .i_cnt_clr(i_cnt_clr), .o_valid(tr_v), .o_data(tr_d), .o_ovf(tr_o), .o_ovf_cnt(tr_n));
    fx_format_convert #(.IW(8), .IF(4), .OW(6), .OF(2), .QUAN_MODE(1)) u_hu (.clk(clk), .rst(rst),
        .i_valid(i_valid), .i_data(i_d8), .i_cnt_clr(i_cnt_clr), .o_valid(hu_v), .o_data(hu_d), .o_ovf(hu_o), .o_ovf_cnt(hu_n));
    fx_format_convert #(.IW(8), .IF(4), .OW(6), .OF(2), .QUAN_MODE(2)) u_cv (.clk(clk), .rst(rst),
        .i_valid(i_valid), .i_data(i_d8), .i_cnt_clr(i_cnt_clr), .o_valid(cv_v), .o_data(cv_d), .o_ovf(cv_o), .o_ovf_cnt(cv_n));
    fx_format_convert #(.IW(8), .IF(4), .OW(6), .OF(2), .QUAN_MODE(1), .OVF_MODE(1)) u_hs (.clk(clk), .rst(rst),
        .i_valid(i_valid), .i_data(i_d8), .i_cnt_clr(i_cnt_clr), .o_valid(hs_v), .o_data(hs_d), .o_ovf(hs_o), .o_ovf_cnt(hs_n));

    int   n_asrt = 0, n_fail = 0;
    e16_t q_w[$], q_s[$], q_l[$];
    e8_t  q8[$];
    e16_t last_l = '0;
    logic [2:0] vh = '0;
    int   cnt = 0;
    logic pend = 1'b0, cur_wo = 1'b0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_asrt++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic put16(input logic [15:0] d, input logic [11:0] w, input logic wo,
                         input logic [11:0] s, input logic so);
        i_d16 = d;
        cur_wo = wo;
        q_w.push_back(e16_t'({w, wo}));
        q_s.push_back(e16_t'({s, so}));
        q_l.push_back(e16_t'({w, wo}));
    endtask

    task automatic put8(input logic [7:0] d, input logic [5:0] tr, input logic tro, input logic [5:0] hu,
                        input logic huo, input logic [5:0] cv, input logic cvo, input logic [5:0] hs, input logic hso);
        i_d8 = d;
        q8.push_back(e8_t'({tr, tro, hu, huo, cv, cvo, hs, hso}));
    endtask

    task automatic cyc(input logic v);
        int   nc;
        e16_t e;
        e8_t  f;
        i_valid = v;
        nc = i_cnt_clr ? 0 : (pend && cnt != 15) ? cnt + 1 : cnt;
        pend = v && cur_wo;
        vh = {vh[1:0], v};
        @(posedge clk);
        #1;
        cnt = nc;
        chk("ovf_cnt", {12'd0, c_n}, 16'(nc));
        chk("w_valid", {15'd0, w_v}, {15'd0, vh[0]});
        chk("l_valid", {15'd0, l_v}, {15'd0, vh[2]});
        chk("hs_valid", {15'd0, hs_v}, {15'd0, vh[0]});
        if (w_v && q_w.size() > 0) begin
            e = q_w.pop_front();
            chk("wrap_data", {4'd0, w_d}, {4'd0, e.d});
            chk("wrap_ovf", {15'd0, w_o}, {15'd0, e.o});
        end
        if (s_v && q_s.size() > 0) begin
            e = q_s.pop_front();
            chk("sat_data", {4'd0, s_d}, {4'd0, e.d});
            chk("sat_ovf", {15'd0, s_o}, {15'd0, e.o});
        end
        if (l_v && q_l.size() > 0)
            last_l = q_l.pop_front();
        chk("lat3_data", {4'd0, l_d}, {4'd0, last_l.d});
        chk("lat3_ovf", {15'd0, l_o}, {15'd0, last_l.o});
        if (hs_v && q8.size() > 0) begin
            f = q8.pop_front();
            chk("trunc", {9'd0, tr_d, tr_o}, {9'd0, f.tr, f.tro});
            chk("half_up", {9'd0, hu_d, hu_o}, {9'd0, f.hu, f.huo});
            chk("conv", {9'd0, cv_d, cv_o}, {9'd0, f.cv, f.cvo});
            chk("half_sat", {9'd0, hs_d, hs_o}, {9'd0, f.hs, f.hso});
        end
    endtask

    task automatic do_rst(input logic v);
        rst = 1'b1;
        i_valid = v;
        @(posedge clk);
        #1;
        rst = 1'b0;
        i_valid = 1'b0;
        q_w.delete(); q_s.delete(); q_l.delete(); q8.delete();
        vh = '0; cnt = 0; pend = 1'b0; last_l = '0;
        chk("rst_w_valid", {15'd0, w_v}, 16'd0);
        chk("rst_l_valid", {15'd0, l_v}, 16'd0);
        chk("rst_l_data", {4'd0, l_d}, 16'd0);
        chk("rst_l_ovf", {15'd0, l_o}, 16'd0);
        chk("rst_s_data", {4'd0, s_d}, 16'd0);
        chk("rst_cnt", {12'd0, c_n}, 16'd0);
        chk("rst_w_cnt", w_n, 16'd0);
        chk("rst_hs_data", {10'd0, hs_d}, 16'd0);
    endtask

    initial begin
        do_rst(1'b0);
        // Formatting, rounding and overflow corner cases, back to back.
        put16(16'h0123, 12'h48C, 0, 12'h48C, 0); put8(8'h06, 6'h01, 0, 6'h02, 0, 6'h02, 0, 6'h02, 0); cyc(1);
        put16(16'h0300, 12'hC00, 1, 12'h7FF, 1); put8(8'h0A, 6'h02, 0, 6'h03, 0, 6'h02, 0, 6'h03, 0); cyc(1);
        put16(16'hFC00, 12'h000, 1, 12'h800, 1); put8(8'hFA, 6'h3E, 0, 6'h3F, 0, 6'h3E, 0, 6'h3F, 0); cyc(1);
        put16(16'hFE00, 12'h800, 0, 12'h800, 0); put8(8'h7F, 6'h1F, 0, 6'h20, 1, 6'h20, 1, 6'h1F, 1); cyc(1);
        put16(16'h01FF, 12'h7FC, 0, 12'h7FC, 0); put8(8'h7E, 6'h1F, 0, 6'h20, 1, 6'h20, 1, 6'h1F, 1); cyc(1);
        put16(16'h0200, 12'h800, 1, 12'h7FF, 1); put8(8'h80, 6'h20, 0, 6'h20, 0, 6'h20, 0, 6'h20, 0); cyc(1);
        put16(16'h0000, 12'h000, 0, 12'h000, 0); put8(8'h02, 6'h00, 0, 6'h01, 0, 6'h00, 0, 6'h01, 0); cyc(1);
        repeat (3) cyc(0);
        // Gapped valid pattern 1,0,1,1: outputs hold through the gap.
        put16(16'h0123, 12'h48C, 0, 12'h48C, 0); put8(8'h06, 6'h01, 0, 6'h02, 0, 6'h02, 0, 6'h02, 0); cyc(1);
        i_d16 = 16'h0300; i_d8 = 8'h7F; cyc(0);
        put16(16'h01FF, 12'h7FC, 0, 12'h7FC, 0); put8(8'h0A, 6'h02, 0, 6'h03, 0, 6'h02, 0, 6'h03, 0); cyc(1);
        put16(16'hFE00, 12'h800, 0, 12'h800, 0); put8(8'hFA, 6'h3E, 0, 6'h3F, 0, 6'h3E, 0, 6'h3F, 0); cyc(1);
        repeat (3) cyc(0);
        // Overflow counter saturation, then clear racing an overflowing output.
        repeat (20) begin
            put16(16'h0300, 12'hC00, 1, 12'h7FF, 1); put8(8'h06, 6'h01, 0, 6'h02, 0, 6'h02, 0, 6'h02, 0); cyc(1);
        end
        i_cnt_clr = 1'b1;
        put16(16'h0300, 12'hC00, 1, 12'h7FF, 1); put8(8'h06, 6'h01, 0, 6'h02, 0, 6'h02, 0, 6'h02, 0); cyc(1);
        i_cnt_clr = 1'b0;
        repeat (2) cyc(0);
        // Reset with samples in flight discards them.
        put16(16'h0300, 12'hC00, 1, 12'h7FF, 1); put8(8'h0A, 6'h02, 0, 6'h03, 0, 6'h02, 0, 6'h03, 0); cyc(1);
        put16(16'h0123, 12'h48C, 0, 12'h48C, 0); put8(8'hFA, 6'h3E, 0, 6'h3F, 0, 6'h3E, 0, 6'h3F, 0); cyc(1);
        put16(16'hFC00, 12'h000, 1, 12'h800, 1); put8(8'h7F, 6'h1F, 0, 6'h20, 1, 6'h20, 1, 6'h1F, 1);
        do_rst(1'b1);
        repeat (3) cyc(0);
        put16(16'h0200, 12'h800, 1, 12'h7FF, 1); put8(8'h7E, 6'h1F, 0, 6'h20, 1, 6'h20, 1, 6'h1F, 1); cyc(1);
        repeat (3) cyc(0);
        chk("drain", 16'(q_w.size() + q_s.size() + q_l.size() + q8.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
